// File: rtl/register_rename_pkg.sv
// Shared rename-stage types and sizes, also used by the ROB and issue blocks.
package rename_pkg;

  localparam int NUM_ARCH = 32;
  localparam int NUM_PHYS = 64;
  localparam int AREG_W   = 5;
  localparam int PREG_W   = 6;
  localparam int FL_DEPTH = NUM_PHYS - NUM_ARCH;
  localparam int FL_PTR_W = $clog2(FL_DEPTH);
  localparam int FL_CNT_W = FL_PTR_W + 1;

  typedef logic [AREG_W-1:0] areg_t;
  typedef logic [PREG_W-1:0] preg_t;

  // One allocation record as presented to the ROB and issue.
  typedef struct packed {
    preg_t dest;
    preg_t old_dest;
    preg_t prs1;
    preg_t prs2;
  } alloc_t;

  // x0 is hardwired zero, so writing it never consumes a physical register.
  function automatic logic needs_dest(input logic has_rd, input areg_t rd);
    return has_rd && (rd != '0);
  endfunction

endpackage

// File: rtl/register_rename_if.sv
// Decode, ROB-allocation and ROB-commit signals of the rename stage.
//
// Handshakes: decode -> rename transfers at a rising edge where dec_valid && dec_ready;
// rename -> ROB transfers at a rising edge where alloc_valid && alloc_ready, and
// alloc_valid plus its payload (alloc_dest, alloc_oldDest, ren_prs1, ren_prs2) stay
// stable while alloc_valid && !alloc_ready. dec_ready never depends on dec_valid.
// commit_valid has no back-pressure: the free list always takes (or drops) it.
interface register_rename_if;
  import rename_pkg::*;

  logic  dec_valid;
  logic  dec_ready;
  logic  dec_has_rd;
  areg_t dec_rd;
  areg_t dec_rs1;
  areg_t dec_rs2;
  preg_t ren_prs1;
  preg_t ren_prs2;
  logic  alloc_valid;
  preg_t alloc_dest;
  preg_t alloc_oldDest;
  logic  alloc_ready;
  logic  commit_valid;
  preg_t free_oldDest;
  preg_t free_count;
  logic  err_overflow;

  // Rename side.
  modport slave (
    input  dec_valid, dec_has_rd, dec_rd, dec_rs1, dec_rs2,
    input  alloc_ready, commit_valid, free_oldDest,
    output dec_ready, ren_prs1, ren_prs2,
    output alloc_valid, alloc_dest, alloc_oldDest,
    output free_count, err_overflow
  );

  // Decode / ROB side.
  modport master (
    output dec_valid, dec_has_rd, dec_rd, dec_rs1, dec_rs2,
    output alloc_ready, commit_valid, free_oldDest,
    input  dec_ready, ren_prs1, ren_prs2,
    input  alloc_valid, alloc_dest, alloc_oldDest,
    input  free_count, err_overflow
  );

endinterface

// File: rtl/register_rename_free_list.sv
// Circular FIFO of free physical registers. Starts full with 32..63 in pop order.
// A register pushed in a cycle is not visible to a pop in that same cycle.
module phys_free_list
  import rename_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pop,
  input  logic                push,
  input  preg_t               push_reg,
  output preg_t               head_reg,
  output logic [FL_CNT_W-1:0] count,
  output logic                overflow
);

  localparam logic [FL_CNT_W-1:0] FULL_CNT = FL_CNT_W'(FL_DEPTH);

  preg_t                mem [FL_DEPTH];
  logic [FL_PTR_W-1:0]  head;
  logic [FL_PTR_W-1:0]  tail;

  logic do_pop;
  logic push_req;
  logic do_push;
  logic drop;

  // Pop/push qualification; phys 0 is never released, a push into a full list is dropped.
  always_comb begin
    do_pop   = pop && (count != '0);
    push_req = push && (push_reg != '0);
    do_push  = push_req && ((count != FULL_CNT) || do_pop);
    drop     = push_req && (count == FULL_CNT) && !do_pop;
  end

  assign head_reg = mem[head];

  // Storage, pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        mem[i] <= preg_t'(NUM_ARCH + i);
      end
      head     <= '0;
      tail     <= '0;
      count    <= FULL_CNT;
      overflow <= 1'b0;
    end else begin
      if (do_pop) begin
        head <= head + 1'b1;
      end
      if (do_push) begin
        mem[tail] <= push_reg;
        tail      <= tail + 1'b1;
      end
      if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end else if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/register_rename.sv
// Rename stage: RAT lookup/update, free-list pop on destination, ROB allocation
// output register, and free-list refill from ROB commit.
module register_rename
  import rename_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  register_rename_if.slave rif
);

  preg_t               rat [NUM_ARCH];
  alloc_t              out_q;
  logic                out_valid;
  preg_t               fl_head;
  logic [FL_CNT_W-1:0] fl_count;
  logic                fl_overflow;

  logic needs_rd;
  logic ready;
  logic accept;
  logic pop;

  // Accept when the output slot is free or draining, and a phys reg is available if needed.
  always_comb begin
    needs_rd = needs_dest(rif.dec_has_rd, rif.dec_rd);
    ready    = (!out_valid || rif.alloc_ready) && (!needs_rd || (fl_count != '0));
    accept   = rif.dec_valid && ready;
    pop      = accept && needs_rd;
  end

  phys_free_list u_free_list (
    .clk      (clk),
    .reset_n  (reset_n),
    .pop      (pop),
    .push     (rif.commit_valid),
    .push_reg (rif.free_oldDest),
    .head_reg (fl_head),
    .count    (fl_count),
    .overflow (fl_overflow)
  );

  // RAT: identity map at reset; a renamed destination points at the popped head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        rat[i] <= preg_t'(i);
      end
    end else if (pop) begin
      rat[rif.dec_rd] <= fl_head;
    end
  end

  // Allocation output register; sources read the RAT before this edge's update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      out_q.prs1     <= rat[rif.dec_rs1];
      out_q.prs2     <= rat[rif.dec_rs2];
      out_q.dest     <= needs_rd ? fl_head : '0;
      out_q.old_dest <= needs_rd ? rat[rif.dec_rd] : '0;
    end else if (rif.alloc_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign rif.dec_ready     = ready;
  assign rif.alloc_valid   = out_valid;
  assign rif.alloc_dest    = out_q.dest;
  assign rif.alloc_oldDest = out_q.old_dest;
  assign rif.ren_prs1      = out_q.prs1;
  assign rif.ren_prs2      = out_q.prs2;
  assign rif.free_count    = PREG_W'(fl_count);
  assign rif.err_overflow  = fl_overflow;

endmodule

// File: tb/tb_register_rename.sv
// Bench for register_rename: reference RAT/free-list model feeding an expected queue.
module tb_register_rename;
  import rename_pkg::*;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  register_rename_if rif ();

  register_rename dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rif     (rif)
  );

  int total = 0;
  int bad   = 0;
  int xfers = 0;

  logic [23:0] exp_q[$];
  preg_t       m_rat [NUM_ARCH];
  preg_t       m_fl[$];
  logic        m_err;
  logic [23:0] mon_exp;
  logic [23:0] mon_act;

  // ---------------- model ----------------
  function automatic void model_reset();
    for (int i = 0; i < NUM_ARCH; i++) m_rat[i] = preg_t'(i);
    m_fl.delete();
    for (int i = 0; i < FL_DEPTH; i++) m_fl.push_back(preg_t'(NUM_ARCH + i));
    exp_q.delete();
    m_err = 1'b0;
  endfunction

  function automatic void model_accept(input logic has, input areg_t rd, input areg_t rs1,
                                       input areg_t rs2);
    preg_t d;
    preg_t o;
    d = '0;
    o = '0;
    if (has && rd != 0) begin
      d = m_fl.pop_front();
      o = m_rat[rd];
    end
    exp_q.push_back({d, o, m_rat[rs1], m_rat[rs2]});
    if (has && rd != 0) m_rat[rd] = d;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset_n && rif.alloc_valid && rif.alloc_ready) begin
      total++;
      xfers++;
      mon_act = {rif.alloc_dest, rif.alloc_oldDest, rif.ren_prs1, rif.ren_prs2};
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL alloc_unexpected got=%h want=none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          bad++;
          $display("FAIL alloc got(dest,old,prs1,prs2)=%h want=%h", mon_act, mon_exp);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic idle();
    rif.dec_valid  = 1'b0;
    rif.dec_has_rd = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n          = 1'b0;
    rif.dec_valid    = 1'b0;
    rif.dec_has_rd   = 1'b0;
    rif.dec_rd       = '0;
    rif.dec_rs1      = '0;
    rif.dec_rs2      = '0;
    rif.alloc_ready  = 1'b1;
    rif.commit_valid = 1'b0;
    rif.free_oldDest = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Present one instruction (called at posedge+1) and hold it until accepted.
  task automatic send(input logic has, input areg_t rd, input areg_t rs1, input areg_t rs2,
                      output int waits);
    rif.dec_valid  = 1'b1;
    rif.dec_has_rd = has;
    rif.dec_rd     = rd;
    rif.dec_rs1    = rs1;
    rif.dec_rs2    = rs2;
    waits = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (rif.dec_ready) begin
        model_accept(has, rd, rs1, rs2);
        @(posedge clk);
        #1;
        return;
      end
      waits++;
      @(posedge clk);
      #1;
    end
    total++;
    bad++;
    $display("FAIL send_timeout got=no_accept want=accept rd=%0d", rd);
  endtask

  // One commit cycle with no rename accepted in the same cycle.
  task automatic commit_cycle(input preg_t r);
    rif.commit_valid = 1'b1;
    rif.free_oldDest = r;
    @(negedge clk);
    if (r != 0) begin
      if (m_fl.size() == FL_DEPTH) m_err = 1'b1;
      else m_fl.push_back(r);
    end
    @(posedge clk);
    #1;
    rif.commit_valid = 1'b0;
    rif.free_oldDest = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    total++; if (rif.free_count !== 6'd32) begin bad++; $display("FAIL reset_count got=%0d want=32", rif.free_count); end
    total++; if (rif.alloc_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", rif.alloc_valid); end
    total++; if (rif.alloc_dest !== 6'd0) begin bad++; $display("FAIL reset_dest got=%0d want=0", rif.alloc_dest); end
    total++; if (rif.alloc_oldDest !== 6'd0) begin bad++; $display("FAIL reset_old got=%0d want=0", rif.alloc_oldDest); end
    total++; if ({rif.ren_prs1, rif.ren_prs2} !== 12'd0) begin bad++; $display("FAIL reset_prs got=%h want=0", {rif.ren_prs1, rif.ren_prs2}); end
    total++; if (rif.err_overflow !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", rif.err_overflow); end
    total++; if (rif.dec_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", rif.dec_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_rename_basic();
    int w;
    send(1'b1, 5'd5, 5'd5, 5'd0, w);
    idle();
    @(negedge clk);
    total++; if (rif.alloc_valid !== 1'b1) begin bad++; $display("FAIL basic_latency got=%b want=1", rif.alloc_valid); end
    total++; if (rif.free_count !== 6'd31) begin bad++; $display("FAIL basic_count got=%0d want=31", rif.free_count); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int w;
    send(1'b1, 5'd6, 5'd5, 5'd0, w);
    total++; if (w != 0) begin bad++; $display("FAIL b2b_first got=%0d waits want=0", w); end
    for (int i = 0; i < 6; i++) begin
      send(1'($urandom_range(0, 1)), areg_t'($urandom_range(0, 31)),
           areg_t'($urandom_range(0, 31)), areg_t'($urandom_range(0, 31)), w);
      total++; if (w != 0) begin bad++; $display("FAIL b2b_stall got=%0d waits want=0 i=%0d", w, i); end
    end
    idle();
    @(negedge clk);
    total++; if (rif.free_count !== preg_t'(m_fl.size())) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", rif.free_count, m_fl.size()); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_exhaust();
    int w;
    apply_reset();
    for (int i = 0; i < FL_DEPTH; i++) begin
      send(1'b1, areg_t'(1 + (i % 31)), areg_t'($urandom_range(0, 31)),
           areg_t'($urandom_range(0, 31)), w);
    end
    idle();
    @(negedge clk);
    total++; if (rif.free_count !== 6'd0) begin bad++; $display("FAIL exhaust_count got=%0d want=0", rif.free_count); end
    @(posedge clk);
    #1;
    rif.dec_valid  = 1'b1;
    rif.dec_has_rd = 1'b1;
    rif.dec_rd     = 5'd7;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++; if (rif.dec_ready !== 1'b0) begin bad++; $display("FAIL exhaust_stall got=%b want=0", rif.dec_ready); end
      @(posedge clk);
      #1;
    end
    send(1'b1, 5'd0, 5'd3, 5'd4, w);
    total++; if (w != 0) begin bad++; $display("FAIL exhaust_x0 got=%0d waits want=0", w); end
    idle();
  endtask

  task automatic test_commit_stall();
    int w;
    rif.dec_valid    = 1'b1;
    rif.dec_has_rd   = 1'b1;
    rif.dec_rd       = 5'd9;
    rif.dec_rs1      = 5'd1;
    rif.dec_rs2      = 5'd2;
    rif.commit_valid = 1'b1;
    rif.free_oldDest = 6'd5;
    @(negedge clk);
    total++; if (rif.dec_ready !== 1'b0) begin bad++; $display("FAIL nobypass_ready got=%b want=0", rif.dec_ready); end
    m_fl.push_back(6'd5);
    @(posedge clk);
    #1;
    rif.commit_valid = 1'b0;
    rif.free_oldDest = '0;
    send(1'b1, 5'd9, 5'd1, 5'd2, w);
    total++; if (w != 0) begin bad++; $display("FAIL refill_accept got=%0d waits want=0", w); end
    idle();
    for (int i = 0; i < 10; i++) commit_cycle(preg_t'(40 + i));
    @(negedge clk);
    total++; if (rif.free_count !== 6'd10) begin bad++; $display("FAIL refill_count got=%0d want=10", rif.free_count); end
    @(posedge clk);
    #1;
    rif.dec_valid    = 1'b1;
    rif.dec_has_rd   = 1'b1;
    rif.dec_rd       = 5'd3;
    rif.dec_rs1      = 5'd9;
    rif.dec_rs2      = 5'd3;
    rif.commit_valid = 1'b1;
    rif.free_oldDest = 6'd50;
    @(negedge clk);
    total++; if (rif.dec_ready !== 1'b1) begin bad++; $display("FAIL popush_ready got=%b want=1", rif.dec_ready); end
    model_accept(1'b1, 5'd3, 5'd9, 5'd3);
    m_fl.push_back(6'd50);
    @(posedge clk);
    #1;
    rif.commit_valid = 1'b0;
    rif.free_oldDest = '0;
    idle();
    @(negedge clk);
    total++; if (rif.free_count !== 6'd10) begin bad++; $display("FAIL popush_count got=%0d want=10", rif.free_count); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_alloc_stall();
    int w;
    int x0;
    logic [23:0] e;
    rif.alloc_ready = 1'b0;
    send(1'b1, 5'd11, 5'd3, 5'd4, w);
    rif.dec_has_rd = 1'b1;
    rif.dec_rd     = 5'd12;
    rif.dec_rs1    = 5'd11;
    rif.dec_rs2    = 5'd9;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      e = exp_q[0];
      total++; if (rif.alloc_valid !== 1'b1) begin bad++; $display("FAIL hold_valid got=%b want=1", rif.alloc_valid); end
      total++; if (rif.dec_ready !== 1'b0) begin bad++; $display("FAIL hold_ready got=%b want=0", rif.dec_ready); end
      total++; if ({rif.alloc_dest, rif.alloc_oldDest, rif.ren_prs1, rif.ren_prs2} !== e) begin
        bad++; $display("FAIL hold_data got=%h want=%h", {rif.alloc_dest, rif.alloc_oldDest, rif.ren_prs1, rif.ren_prs2}, e);
      end
      @(posedge clk);
      #1;
    end
    x0 = xfers;
    rif.alloc_ready = 1'b1;
    @(negedge clk);
    total++; if (rif.dec_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b want=1", rif.dec_ready); end
    model_accept(1'b1, 5'd12, 5'd11, 5'd9);
    @(posedge clk);
    #1;
    idle();
    total++; if (xfers != x0 + 1) begin bad++; $display("FAIL release_single got=%0d want=%0d", xfers - x0, 1); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (exp_q.size() != 0 || rif.alloc_valid !== 1'b0) begin
      bad++; $display("FAIL release_drain got=q%0d/v%b want=q0/v0", exp_q.size(), rif.alloc_valid);
    end
  endtask

  task automatic test_overflow();
    int w;
    apply_reset();
    commit_cycle(6'd0);
    @(negedge clk);
    total++; if ({rif.free_count, rif.err_overflow} !== {6'd32, 1'b0}) begin bad++; $display("FAIL commit0_full got=%0d/%b want=32/0", rif.free_count, rif.err_overflow); end
    @(posedge clk);
    #1;
    commit_cycle(6'd40);
    @(negedge clk);
    total++; if (rif.err_overflow !== m_err || m_err !== 1'b1) begin bad++; $display("FAIL ovf_err got=%b want=1", rif.err_overflow); end
    total++; if (rif.free_count !== 6'd32) begin bad++; $display("FAIL ovf_count got=%0d want=32", rif.free_count); end
    @(posedge clk);
    #1;
    send(1'b1, 5'd8, 5'd8, 5'd1, w);
    idle();
    commit_cycle(6'd0);
    @(negedge clk);
    total++; if ({rif.free_count, rif.err_overflow} !== {6'd31, 1'b1}) begin bad++; $display("FAIL ovf_sticky got=%0d/%b want=31/1", rif.free_count, rif.err_overflow); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int w;
    rif.alloc_ready = 1'b0;
    send(1'b1, 5'd13, 5'd1, 5'd1, w);
    idle();
    reset_n = 1'b0;
    #1;
    total++; if ({rif.alloc_valid, rif.free_count, rif.err_overflow} !== {1'b0, 6'd32, 1'b0}) begin
      bad++; $display("FAIL midreset got=%b/%0d/%b want=0/32/0", rif.alloc_valid, rif.free_count, rif.err_overflow);
    end
    model_reset();
    rif.alloc_ready = 1'b1;
    @(posedge clk);
    #1 reset_n = 1'b1;
    send(1'b1, 5'd5, 5'd5, 5'd0, w);
    idle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rename_basic();
    test_back_to_back();
    test_exhaust();
    test_commit_stall();
    test_alloc_stall();
    test_overflow();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL final_drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
